tick_pwm_generator: RTL and testbench

//  Downstream consumer of the dynamic clock divider's single-cycle enable strobe.

---
 rtl/tick_pwm_generator.sv | 152 +++++++++++++++
 tb/tb_tick_pwm_generator.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/tick_pwm_generator.sv
// rtl/tick_pwm_generator.sv - tick-driven PWM generator with boundary-staged period/duty updates
module tick_pwm_generator #(
  parameter int WIDTH = 16
) (
  input  logic             i_CLK,
  input  logic             i_RESET_N,
  input  logic             i_ENABLE,
  input  logic             i_TICK,
  input  logic             i_LOAD,
  input  logic [WIDTH-1:0] i_PERIOD,
  input  logic [WIDTH-1:0] i_DUTY,
  output logic             o_PWM,
  output logic             o_PERIOD_DONE,
  output logic             o_LOAD_ACK
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state;
  state_t           state_next;

  logic [WIDTH-1:0] phase;
  logic [WIDTH-1:0] phase_next;

  logic [WIDTH-1:0] act_p;
  logic [WIDTH-1:0] act_d;
  logic [WIDTH-1:0] pend_p;
  logic [WIDTH-1:0] pend_d;
  logic             pend_valid;

  // Values that would become active if a pending update is applied this
  // cycle; a same-cycle load overrides whatever was already pending.
  logic [WIDTH-1:0] src_p;
  logic [WIDTH-1:0] src_d;
  logic             pend_any;

  logic [WIDTH-1:0] eff_last;
  logic             boundary;
  logic             apply;
  logic [WIDTH-1:0] d_after;
  logic             pwm_next;
  logic             done_next;
  logic             ack_next;

  assign src_p    = i_LOAD ? i_PERIOD : pend_p;
  assign src_d    = i_LOAD ? i_DUTY   : pend_d;
  assign pend_any = pend_valid | i_LOAD;

  // A zero period behaves as a period of one tick, so the last phase is 0.
  assign eff_last = (act_p == '0) ? '0 : act_p - WIDTH'(1);
  assign boundary = (phase == eff_last);

  // State register.
  always_ff @(posedge i_CLK or negedge i_RESET_N) begin
    if (!i_RESET_N) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: enable alone moves between IDLE and RUN.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (i_ENABLE)  state_next = RUN;
      RUN:     if (!i_ENABLE) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output/datapath logic: next phase, staged-update application and next output values.
  always_comb begin
    phase_next = phase;
    apply      = 1'b0;
    pwm_next   = o_PWM;
    done_next  = 1'b0;
    ack_next   = 1'b0;
    d_after    = act_d;
    case (state)
      IDLE: begin
        pwm_next = 1'b0;
        if (i_ENABLE) begin
          phase_next = '0;
          apply      = pend_any;
          ack_next   = pend_any;
          d_after    = pend_any ? src_d : act_d;
          pwm_next   = (d_after != '0);
        end
      end
      RUN: begin
        if (!i_ENABLE) begin
          phase_next = '0;
          pwm_next   = 1'b0;
        end else if (i_TICK) begin
          if (boundary) begin
            phase_next = '0;
            done_next  = 1'b1;
            apply      = pend_any;
            ack_next   = pend_any;
          end else begin
            phase_next = phase + WIDTH'(1);
          end
          d_after  = apply ? src_d : act_d;
          pwm_next = (phase_next < d_after);
        end
      end
      default: begin
        phase_next = '0;
        pwm_next   = 1'b0;
      end
    endcase
  end

  // Phase counter and registered outputs.
  always_ff @(posedge i_CLK or negedge i_RESET_N) begin
    if (!i_RESET_N) begin
      phase         <= '0;
      o_PWM         <= 1'b0;
      o_PERIOD_DONE <= 1'b0;
      o_LOAD_ACK    <= 1'b0;
    end else begin
      phase         <= phase_next;
      o_PWM         <= pwm_next;
      o_PERIOD_DONE <= done_next;
      o_LOAD_ACK    <= ack_next;
    end
  end

  // Active and pending period/duty; an applied update consumes the pending slot.
  always_ff @(posedge i_CLK or negedge i_RESET_N) begin
    if (!i_RESET_N) begin
      act_p      <= '0;
      act_d      <= '0;
      pend_p     <= '0;
      pend_d     <= '0;
      pend_valid <= 1'b0;
    end else if (apply) begin
      act_p      <= src_p;
      act_d      <= src_d;
      pend_valid <= 1'b0;
    end else if (i_LOAD) begin
      pend_p     <= i_PERIOD;
      pend_d     <= i_DUTY;
      pend_valid <= 1'b1;
    end
  end

endmodule

// File: tb/tb_tick_pwm_generator.sv
// tb/tb_tick_pwm_generator.sv - directed vector bench for tick_pwm_generator
module tb_tick_pwm_generator;

  logic        clk;
  logic        rst_n;
  logic        enable;
  logic        tick;
  logic        load;
  logic [15:0] period;
  logic [15:0] duty;
  logic        pwm;
  logic        period_done;
  logic        load_ack;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic        en;
    logic        tk;
    logic        ld;
    logic [15:0] p;
    logic [15:0] d;
    logic        e_pwm;
    logic        e_done;
    logic        e_ack;
  } vec_t;

  vec_t vecs[$];

  tick_pwm_generator #(.WIDTH(16)) dut (
    .i_CLK         (clk),
    .i_RESET_N     (rst_n),
    .i_ENABLE      (enable),
    .i_TICK        (tick),
    .i_LOAD        (load),
    .i_PERIOD      (period),
    .i_DUTY        (duty),
    .o_PWM         (pwm),
    .o_PERIOD_DONE (period_done),
    .o_LOAD_ACK    (load_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t v(input logic en, input logic tk, input logic ld,
                             input int p, input int d,
                             input logic e_pwm, input logic e_done, input logic e_ack);
    vec_t r;
    r.en = en; r.tk = tk; r.ld = ld;
    r.p = 16'(p); r.d = 16'(d);
    r.e_pwm = e_pwm; r.e_done = e_done; r.e_ack = e_ack;
    return r;
  endfunction

  task automatic check(input string name, input int idx, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s [%0d]: got %b expected %b", name, idx, act, exp);
    end
  endtask

  task automatic check_all(input int idx, input logic e_pwm, input logic e_done, input logic e_ack);
    check("pwm",  idx, pwm,         e_pwm);
    check("done", idx, period_done, e_done);
    check("ack",  idx, load_ack,    e_ack);
  endtask

  // Drive one cycle of inputs, then sample outputs just after the edge.
  task automatic step(input vec_t t, input int idx);
    enable = t.en; tick = t.tk; load = t.ld; period = t.p; duty = t.d;
    @(posedge clk);
    #1;
    check_all(idx, t.e_pwm, t.e_done, t.e_ack);
  endtask

  initial begin
    // Loads while idle, last one wins; enable applies P=4,D=1; ticks every 3rd clock.
    vecs.push_back(v(0,0,1,7,7, 0,0,0));
    vecs.push_back(v(0,1,1,4,1, 0,0,0));
    vecs.push_back(v(1,0,0,0,0, 1,0,1));
    vecs.push_back(v(1,1,0,0,0, 0,0,0));
    vecs.push_back(v(1,0,0,0,0, 0,0,0));
    vecs.push_back(v(1,0,0,0,0, 0,0,0));
    vecs.push_back(v(1,1,0,0,0, 0,0,0));
    vecs.push_back(v(1,0,0,0,0, 0,0,0));
    vecs.push_back(v(1,0,0,0,0, 0,0,0));
    vecs.push_back(v(1,1,0,0,0, 0,0,0));
    vecs.push_back(v(1,0,0,0,0, 0,0,0));
    vecs.push_back(v(1,0,0,0,0, 0,0,0));
    vecs.push_back(v(1,1,0,0,0, 1,1,0));
    vecs.push_back(v(1,0,0,0,0, 1,0,0));
    vecs.push_back(v(1,0,0,0,0, 1,0,0));
    vecs.push_back(v(1,1,0,0,0, 0,0,0));
    // P=4,D=2 running; load P=2,D=1 at phase 1 completes the old period first.
    vecs.push_back(v(0,0,0,0,0, 0,0,0));
    vecs.push_back(v(1,0,1,4,2, 1,0,1));
    vecs.push_back(v(1,1,0,0,0, 1,0,0));
    vecs.push_back(v(1,1,1,2,1, 0,0,0));
    vecs.push_back(v(1,1,0,0,0, 0,0,0));
    vecs.push_back(v(1,1,0,0,0, 1,1,1));
    vecs.push_back(v(1,1,0,0,0, 0,0,0));
    vecs.push_back(v(1,1,0,0,0, 1,1,0));
    vecs.push_back(v(1,0,0,0,0, 1,0,0));
    // D=0 then D=5 with P=4.
    vecs.push_back(v(1,1,1,4,0, 0,0,0));
    vecs.push_back(v(1,1,0,0,0, 0,1,1));
    vecs.push_back(v(1,1,0,0,0, 0,0,0));
    vecs.push_back(v(1,1,0,0,0, 0,0,0));
    vecs.push_back(v(1,1,0,0,0, 0,0,0));
    vecs.push_back(v(1,1,0,0,0, 0,1,0));
    vecs.push_back(v(1,1,1,4,5, 0,0,0));
    vecs.push_back(v(1,1,0,0,0, 0,0,0));
    vecs.push_back(v(1,1,0,0,0, 0,0,0));
    vecs.push_back(v(1,1,0,0,0, 1,1,1));
    vecs.push_back(v(1,1,0,0,0, 1,0,0));
    vecs.push_back(v(1,1,0,0,0, 1,0,0));
    vecs.push_back(v(1,1,0,0,0, 1,0,0));
    vecs.push_back(v(1,1,0,0,0, 1,1,0));
    vecs.push_back(v(1,1,0,0,0, 1,0,0));
    vecs.push_back(v(1,1,0,0,0, 1,0,0));
    vecs.push_back(v(1,1,0,0,0, 1,0,0));
    vecs.push_back(v(1,1,0,0,0, 1,1,0));
    // P=0,D=1: every tick is a boundary.
    vecs.push_back(v(1,1,1,0,1, 1,0,0));
    vecs.push_back(v(1,1,0,0,0, 1,0,0));
    vecs.push_back(v(1,1,0,0,0, 1,0,0));
    vecs.push_back(v(1,1,0,0,0, 1,1,1));
    vecs.push_back(v(1,1,0,0,0, 1,1,0));
    vecs.push_back(v(1,1,0,0,0, 1,1,0));
    vecs.push_back(v(1,1,0,0,0, 1,1,0));
    // P=4,D=3; drop enable with a tick at phase 2, then re-enable from phase 0.
    vecs.push_back(v(1,1,1,4,3, 1,1,1));
    vecs.push_back(v(1,1,0,0,0, 1,0,0));
    vecs.push_back(v(1,1,0,0,0, 1,0,0));
    vecs.push_back(v(0,1,0,0,0, 0,0,0));
    vecs.push_back(v(0,1,0,0,0, 0,0,0));
    vecs.push_back(v(1,0,0,0,0, 1,0,0));
    vecs.push_back(v(1,1,0,0,0, 1,0,0));
    vecs.push_back(v(1,1,0,0,0, 1,0,0));
    vecs.push_back(v(1,1,0,0,0, 0,0,0));
    vecs.push_back(v(1,1,0,0,0, 1,1,0));
    // Stage a pending load while running with PWM high.
    vecs.push_back(v(1,0,1,4,2, 1,0,0));

    rst_n = 1'b0; enable = 1'b0; tick = 1'b0; load = 1'b0; period = '0; duty = '0;
    repeat (2) @(posedge clk);
    #1;
    check_all(-1, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i], i);
    end

    // Asynchronous reset between clock edges with a pending load outstanding.
    #3 rst_n = 1'b0;
    #1;
    check_all(100, 1'b0, 1'b0, 1'b0);
    #3 rst_n = 1'b1;
    step(v(1,0,0,0,0, 0,0,0), 101);
    step(v(1,1,0,0,0, 0,1,0), 102);
    step(v(1,1,0,0,0, 0,1,0), 103);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
